if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0800: instruction word injected on reset, flush or redirect (decodes as NOP).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 stall  input  1  hazard unit hold request: freeze PC and IF/ID register.
REQ-006 branch_taken  input  1  branch resolved taken.
REQ-007 branch_target  input  16  branch destination word address.
REQ-008 jump  input  1  JR resolved.
REQ-009 jump_target  input  16  JR destination (rx value).
REQ-010 imem_req  output  1  instruction-memory read request.
REQ-011 imem_addr  output  16  instruction fetch word address, equal to PC.
REQ-012 imem_data  input  16  instruction word, valid when imem_ready=1.
REQ-013 imem_ready  input  1  fetch complete this cycle.
REQ-014 instr  output  16  IF/ID instruction register.
REQ-015 pc_out  output  16  fetch address of instr plus 1 (MFPC/branch base).
REQ-016 OP  output  5  instr[15:11].
REQ-017 RegIn1  output  3  instr[10:8].
REQ-018 RegIn2  output  3  instr[7:5].
REQ-019 RegIn3  output  3  instr[4:2].
REQ-020 LastOp  output  5  instr[4:0].
REQ-021 valid  output  1  instr holds a real fetched instruction (0 for injected NOP).

Function
REQ-022 States: FETCH (imem_req=1), HOLD (imem_req=0, fetched word buffered while stalled).
REQ-023 Field outputs OP/RegIn1/RegIn2/RegIn3/LastOp shall be pure combinational slices of registered instr; no added latency.
REQ-024 Per-edge priority: reset > redirect > stall > normal fetch.
REQ-025 Redirect = jump or branch_taken; jump wins if both; PC <= target, instr <= NOP_INSTR, valid <= 0, buffer discarded, state <= FETCH, any in-flight imem_ready ignored that cycle.
REQ-026 FETCH, imem_ready=1, stall=0: instr <= imem_data, pc_out <= PC+1, valid <= 1, PC <= PC+1 (16-bit wrap, 16'hFFFF -> 16'h0000).
REQ-027 FETCH, imem_ready=1, stall=1: imem_data and PC+1 captured to buffer, PC <= PC+1, IF/ID held, state <= HOLD.
REQ-028 FETCH, imem_ready=0: PC held; if stall=0 instr <= NOP_INSTR, valid <= 0 (bubble); if stall=1 IF/ID held.
REQ-029 HOLD, stall=1: everything held, imem_req=0.
REQ-030 HOLD, stall=0: IF/ID <= buffer, valid <= 1, state <= FETCH; fetch of new PC begins same cycle.
REQ-031 imem_addr shall remain stable while imem_req=1 and imem_ready=0.
REQ-032 Each imem_data word shall reach instr exactly once; none dropped or duplicated across stall/HOLD sequences.

Reset
REQ-033 On rising edge with rst=0: PC=RESET_PC, instr=NOP_INSTR, pc_out=RESET_PC, valid=0, buffer cleared, state=FETCH; all other inputs ignored.
REQ-034 Reset mid-fetch or in HOLD shall abandon the transaction; first request after release addresses RESET_PC.
REQ-035 imem_req shall be 0 while rst=0 and 1 on the first cycle after release.

Structure
REQ-036 Shared package holds NOP_INSTR encoding, RESET_PC default, state encoding (FETCH/HOLD) and instruction field bit positions, shared with the decoder.
REQ-037 One sub-module natural: pc_reg (PC register with next-PC mux: sequential/branch/jump/hold).

Verification
REQ-038 Reset release, imem_ready tied 1, imem_data=16'h4A05 -> cycle 1 imem_addr=0000; next edge instr=4A05, OP=5'b01001, RegIn1=3'b010, pc_out=0001, valid=1.
REQ-039 Back-to-back fetch, stall=1 for 3 cycles at PC=0004 with ready=1 -> state HOLD, imem_req=0, instr unchanged; stall drop -> instr = word from 0004, next fetch addr 0005, no duplicate.
REQ-040 branch_taken=1, branch_target=0040 while ready=0 -> next edge instr=0800, valid=0, imem_addr=0040; late ready ignored.
REQ-041 jump=1 (target 0123) and branch_taken=1 (target 0200) same cycle -> imem_addr=0123.
REQ-042 PC=FFFF, ready=1 -> pc_out=0000, next imem_addr=0000.
REQ-043 rst=0 asserted in HOLD -> next edge state FETCH, instr=0800, valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch/decode definitions: NOP encoding, reset PC, fetch FSM states,
// next-PC selector and instruction field bit positions.
package if_stage_pkg;

  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [15:0] RESET_PC_DEF  = 16'h0000;

  // Instruction field positions, shared with the decoder
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 11;
  localparam int RS1_HI  = 10;
  localparam int RS1_LO  = 8;
  localparam int RS2_HI  = 7;
  localparam int RS2_LO  = 5;
  localparam int RS3_HI  = 4;
  localparam int RS3_LO  = 2;
  localparam int LOP_HI  = 4;
  localparam int LOP_LO  = 0;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_SEQ    = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JUMP   = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface if_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_data, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_data, output imem_ready);
endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter with next-PC mux (hold / sequential / branch / jump).
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  pc_sel_t     sel,
  input  logic [15:0] branch_target,
  input  logic [15:0] jump_target,
  output logic [15:0] pc,
  output logic [15:0] pc_inc
);

  // Natural 16-bit wrap: FFFF + 1 -> 0000
  assign pc_inc = pc + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      unique case (sel)
        PC_SEQ:    pc <= pc_inc;
        PC_BRANCH: pc <= branch_target;
        PC_JUMP:   pc <= jump_target;
        default:   pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives the imem bus, owns the IF/ID register and
// buffers one fetched word while the hazard unit stalls.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [15:0]     branch_target,
  input  logic            jump,
  input  logic [15:0]     jump_target,
  if_stage_if.master      imem,
  output logic [15:0]     instr,
  output logic [15:0]     pc_out,
  output logic [4:0]      OP,
  output logic [2:0]      RegIn1,
  output logic [2:0]      RegIn2,
  output logic [2:0]      RegIn3,
  output logic [4:0]      LastOp,
  output logic            valid
);

  state_t      state, state_nxt;
  pc_sel_t     pc_sel;
  logic [15:0] pc, pc_inc;
  logic [15:0] buf_instr, buf_pc;
  logic        redirect, fetch_done;

  assign redirect   = jump | branch_taken;
  // Ready is only meaningful while a request is outstanding
  assign fetch_done = (state == FETCH) && imem.imem_ready;

  always_comb begin
    pc_sel = PC_HOLD;
    if (jump)             pc_sel = PC_JUMP;
    else if (branch_taken) pc_sel = PC_BRANCH;
    else if (fetch_done)   pc_sel = PC_SEQ;
  end

  if_stage_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .sel           (pc_sel),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .pc            (pc),
    .pc_inc        (pc_inc)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = FETCH;
    end else begin
      unique case (state)
        FETCH:   if (fetch_done && stall) state_nxt = HOLD;
        HOLD:    if (!stall)              state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_comb begin
    imem.imem_req  = rst && (state == FETCH);
    imem.imem_addr = pc;
  end

  // IF/ID register and the single-entry stall buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr     <= NOP_INSTR;
      pc_out    <= RESET_PC;
      valid     <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= RESET_PC;
    end else if (redirect) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (state == FETCH) begin
      if (imem.imem_ready) begin
        if (stall) begin
          buf_instr <= imem.imem_data;
          buf_pc    <= pc_inc;
        end else begin
          instr  <= imem.imem_data;
          pc_out <= pc_inc;
          valid  <= 1'b1;
        end
      end else if (!stall) begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end else if (!stall) begin
      instr  <= buf_instr;
      pc_out <= buf_pc;
      valid  <= 1'b1;
    end
  end

  assign OP     = instr[OP_HI:OP_LO];
  assign RegIn1 = instr[RS1_HI:RS1_LO];
  assign RegIn2 = instr[RS2_HI:RS2_LO];
  assign RegIn3 = instr[RS3_HI:RS3_LO];
  assign LastOp = instr[LOP_HI:LOP_LO];

endmodule
